// File: rtl/mano_core_p.sv
// Mano basic computer core: multi-cycle FSM sequencer plus datapath, external word memory, handshaked char I/O.
// Latency: one cycle per FSM state plus memory wait states; direct LDA on 0-wait memory takes 5 cycles.
// Backpressure: every memory state stalls until mem_ack; I/O flows through FGI/FGO ready/valid flags.
// Ports: mclk/mrst clock and async active-low reset; mem_* req/ack memory port (bit DATA_W = even parity);
//   inpr_*/outr_* character I/O; halted/fault status; dbg_pc/dbg_ac register observation.
module mano_core_p #(
  parameter int unsigned  ADDR_W    = 12,
  parameter int unsigned  IO_W      = 8,
  parameter bit           PARITY_EN = 1'b1,
  parameter int unsigned  RESET_PC  = 0,
  localparam int unsigned DATA_W    = ADDR_W + 4
) (
  input  logic              mclk,
  input  logic              mrst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W:0]   mem_wdata,
  input  logic [DATA_W:0]   mem_rdata,
  input  logic              mem_ack,
  input  logic [IO_W-1:0]   inpr_data,
  input  logic              inpr_valid,
  output logic              inpr_ready,
  output logic [IO_W-1:0]   outr_data,
  output logic              outr_valid,
  input  logic              outr_ready,
  output logic              halted,
  output logic              fault,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic [DATA_W-1:0] dbg_ac
);

  localparam logic [3:0] S_FETCH = 4'd0;
  localparam logic [3:0] S_IRD   = 4'd1;
  localparam logic [3:0] S_DEC   = 4'd2;
  localparam logic [3:0] S_IND   = 4'd3;
  localparam logic [3:0] S_RD    = 4'd4;
  localparam logic [3:0] S_EXEC  = 4'd5;
  localparam logic [3:0] S_WB    = 4'd6;
  localparam logic [3:0] S_INT   = 4'd7;
  localparam logic [3:0] S_REG   = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;
  localparam logic [3:0] S_FAULT = 4'd10;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_RIO = 3'd7;

  logic [3:0]        state;
  logic [ADDR_W-1:0] ar, pc;
  logic [DATA_W-1:0] dr, ac, ir, tr;
  logic              e, i_bit, ien, fgi, fgo;
  logic [IO_W-1:0]   inpr, outr;

  logic [2:0]        opcode;
  logic [11:0]       fld;
  logic              fld_1hot, skip, rd_state, par_err, exec_wr;
  logic [DATA_W-1:0] wdat;

  assign opcode   = ir[DATA_W-2:ADDR_W];
  assign fld      = ir[ADDR_W-1:ADDR_W-12];
  assign fld_1hot = $onehot(fld);
  assign rd_state = (state == S_IRD) || (state == S_IND) || (state == S_RD);
  // An odd-parity read is caught in the ack cycle, so the bad word never reaches a register.
  assign par_err  = PARITY_EN && rd_state && mem_ack && (^mem_rdata);
  assign exec_wr  = (state == S_EXEC) && ((opcode == OP_STA) || (opcode == OP_BSA));

  // Skip conditions for register-reference (I=0) and I/O (I=1) instructions; a non one-hot field never skips.
  assign skip = fld_1hot && (i_bit ? ((fld[9] && fgi) || (fld[8] && fgo))
                                   : ((fld[4] && !ac[DATA_W-1]) || (fld[3] && ac[DATA_W-1]) ||
                                      (fld[2] && (ac == '0)) || (fld[1] && !e)));

  // Memory port is decoded from state so an async reset drops mem_req immediately.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = ar;
    wdat     = ac;
    case (state)
      S_IRD, S_IND, S_RD: mem_req = 1'b1;
      S_EXEC: begin
        mem_req = exec_wr;
        mem_we  = exec_wr;
        if (opcode == OP_BSA) wdat = {{(DATA_W-ADDR_W){1'b0}}, pc};
      end
      S_WB: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        wdat    = dr;
      end
      S_INT: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = '0;
        wdat     = tr;
      end
      default: ;
    endcase
  end

  assign mem_wdata  = {PARITY_EN & (^wdat), wdat};
  assign inpr_ready = ~fgi;
  assign outr_valid = ~fgo;
  assign outr_data  = outr;
  assign halted     = (state == S_HALT);
  assign dbg_pc     = pc;
  assign dbg_ac     = ac;

  always_ff @(posedge mclk or negedge mrst) begin
    if (!mrst) begin
      state <= S_FETCH;
      pc    <= ADDR_W'(RESET_PC);
      ar    <= '0;
      dr    <= '0;
      ac    <= '0;
      ir    <= '0;
      tr    <= '0;
      e     <= 1'b0;
      i_bit <= 1'b0;
      ien   <= 1'b0;
      fgi   <= 1'b0;
      fgo   <= 1'b1;
      inpr  <= '0;
      outr  <= '0;
      fault <= 1'b0;
    end else if (par_err) begin
      fault <= 1'b1;
      state <= S_FAULT;
    end else if (state != S_FAULT) begin
      // Output acceptance first so an OUT in the same cycle overrides it below.
      if (outr_valid && outr_ready) fgo <= 1'b1;
      case (state)
        S_FETCH: begin
          if (ien && (fgi || fgo)) begin
            tr    <= {{(DATA_W-ADDR_W){1'b0}}, pc};
            state <= S_INT;
          end else begin
            ar    <= pc;
            state <= S_IRD;
          end
        end
        S_IRD: if (mem_ack) begin
          ir    <= mem_rdata[DATA_W-1:0];
          pc    <= pc + ADDR_W'(1);
          state <= S_DEC;
        end
        S_DEC: begin
          ar    <= ir[ADDR_W-1:0];
          i_bit <= ir[DATA_W-1];
          if (opcode == OP_RIO)                                     state <= S_REG;
          else if (ir[DATA_W-1])                                    state <= S_IND;
          else if (opcode inside {OP_BUN, OP_STA, OP_BSA})          state <= S_EXEC;
          else                                                      state <= S_RD;
        end
        S_IND: if (mem_ack) begin
          ar    <= mem_rdata[ADDR_W-1:0];
          state <= (opcode inside {OP_BUN, OP_STA, OP_BSA}) ? S_EXEC : S_RD;
        end
        S_RD: if (mem_ack) begin
          dr    <= mem_rdata[DATA_W-1:0];
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          case (opcode)
            OP_AND: ac <= ac & dr;
            OP_ADD: {e, ac} <= {1'b0, ac} + {1'b0, dr};
            OP_LDA: ac <= dr;
            OP_BUN: pc <= ar;
            OP_STA: if (!mem_ack) state <= S_EXEC;
            OP_BSA: if (mem_ack) pc <= ar + ADDR_W'(1); else state <= S_EXEC;
            OP_ISZ: begin
              dr    <= dr + DATA_W'(1);
              state <= S_WB;
            end
            default: ;
          endcase
        end
        S_WB: if (mem_ack) begin
          if (dr == '0) pc <= pc + ADDR_W'(1);
          state <= S_FETCH;
        end
        S_INT: if (mem_ack) begin
          pc    <= ADDR_W'(1);
          ien   <= 1'b0;
          state <= S_FETCH;
        end
        S_REG: begin
          state <= S_FETCH;
          if (skip) pc <= pc + ADDR_W'(1);
          if (fld_1hot && !i_bit) begin
            if (fld[11]) ac <= '0;
            if (fld[10]) e  <= 1'b0;
            if (fld[9])  ac <= ~ac;
            if (fld[8])  e  <= ~e;
            if (fld[7]) begin
              ac <= {e, ac[DATA_W-1:1]};
              e  <= ac[0];
            end
            if (fld[6]) begin
              ac <= {ac[DATA_W-2:0], e};
              e  <= ac[DATA_W-1];
            end
            if (fld[5])  ac <= ac + DATA_W'(1);
            if (fld[0])  state <= S_HALT;
          end else if (fld_1hot) begin
            if (fld[11]) begin
              ac[IO_W-1:0] <= inpr;
              fgi          <= 1'b0;
            end
            if (fld[10]) begin
              outr <= ac[IO_W-1:0];
              fgo  <= 1'b0;
            end
            if (fld[7]) ien <= 1'b1;
            if (fld[6]) ien <= 1'b0;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
      // A character offered while ready was high is always taken, even if INP cleared FGI this cycle.
      if (inpr_valid && inpr_ready) begin
        inpr <= inpr_data;
        fgi  <= 1'b1;
      end
    end
  end

endmodule
